// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT matrix sequencer slice.
// FP32 words are treated as opaque 32-bit containers; nothing here does arithmetic on them.
package dct_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned DIM   = 8;
    localparam int unsigned VEC_W = FP_W * DIM;

    typedef logic [FP_W-1:0]  fp32_t;
    typedef logic [VEC_W-1:0] fpvec_t;

    localparam fp32_t FP_ONE  = 32'h3f80_0000;
    localparam fp32_t FP_ZERO = '0;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT
    } seq_state_e;

    // Element 0 sits in the most significant word of a vector.
    function automatic fp32_t vec_lane(fpvec_t v, int unsigned e);
        return v[VEC_W-1-FP_W*e -: FP_W];
    endfunction

endpackage

// File: rtl/dct_matrix_sequencer_if.sv
// Load, multiplier and result buses of the matrix sequencer.
// The sequencer connects through the master modport, its environment through slave.
interface dct_matrix_sequencer_if;
    import dct_pkg::*;

    fpvec_t ld_data;
    logic   ld_valid;
    logic   ld_ready;

    fpvec_t mul_row;
    fpvec_t mul_column;
    logic   mul_validin;
    fp32_t  mul_out;
    logic   mul_validity;

    fp32_t  res_data;
    logic   res_valid;
    logic   res_ready;
    logic   res_last;

    modport master (
        input  ld_data, ld_valid, mul_out, mul_validity, res_ready,
        output ld_ready, mul_row, mul_column, mul_validin, res_data, res_valid, res_last
    );

    modport slave (
        output ld_data, ld_valid, mul_out, mul_validity, res_ready,
        input  ld_ready, mul_row, mul_column, mul_validin, res_data, res_valid, res_last
    );

endinterface

// File: rtl/dct_matrix_sequencer_fp_vec_bank.sv
// Eight-entry bank of 256-bit FP32 vectors: one synchronous write port, one asynchronous read port.
// Contents are not reset; every entry is rewritten before it is read.
module fp_vec_bank
    import dct_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [2:0] waddr_i,
    input  fpvec_t     wdata_i,
    input  logic [2:0] raddr_i,
    output fpvec_t     rdata_o
);

    fpvec_t mem_q [DIM];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dct_matrix_sequencer.sv
// Loads A rows and B columns, issues all 64 row/column pairs to the dot-product unit,
// gathers the results in issue order and streams C = A*B out row-major.
module dct_matrix_sequencer
    import dct_pkg::*;
#(
    parameter int unsigned NPAIR         = 64,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dct_matrix_sequencer_if.master bus,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        lc_q, lc_d;
    logic [5:0]        k_q, k_d;
    logic [6:0]        rc_q, rc_d;
    logic [5:0]        oc_q, oc_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              ld_ready_q, ld_ready_d;
    logic              err_q, err_d;
    logic              mul_valid_q, mul_valid_d;
    fpvec_t            mul_row_q, mul_row_d;
    fpvec_t            mul_col_q, mul_col_d;

    fp32_t             c_q [NPAIR];

    logic              ld_xfer;
    logic              res_xfer;
    logic              capture;
    logic              a_we;
    logic              b_we;
    logic [5:0]        rd_idx;
    fpvec_t            a_rdata;
    fpvec_t            b_rdata;
    logic [IDLE_W-1:0] idle_inc;

    assign ld_xfer  = (state_q == ST_LOAD) && ld_ready_q && bus.ld_valid;
    assign res_xfer = (state_q == ST_OUTPUT) && bus.res_ready;
    assign capture  = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN))
                      && bus.mul_validity && (rc_q != 7'(NPAIR));
    assign a_we     = ld_xfer && !lc_q[3];
    assign b_we     = ld_xfer && lc_q[3];
    assign idle_inc = idle_q + 1'b1;

    // The bank is read one pair ahead so the registered issue outputs line up with k.
    assign rd_idx   = (state_q == ST_ISSUE) ? k_q + 6'd1 : '0;

    fp_vec_bank u_bank_a (
        .clk     (clk),
        .we_i    (a_we),
        .waddr_i (lc_q[2:0]),
        .wdata_i (bus.ld_data),
        .raddr_i (rd_idx[5:3]),
        .rdata_o (a_rdata)
    );

    fp_vec_bank u_bank_b (
        .clk     (clk),
        .we_i    (b_we),
        .waddr_i (lc_q[2:0]),
        .wdata_i (bus.ld_data),
        .raddr_i (rd_idx[2:0]),
        .rdata_o (b_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            lc_q        <= '0;
            k_q         <= '0;
            rc_q        <= '0;
            oc_q        <= '0;
            idle_q      <= '0;
            ld_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            mul_valid_q <= 1'b0;
            mul_row_q   <= '0;
            mul_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            lc_q        <= lc_d;
            k_q         <= k_d;
            rc_q        <= rc_d;
            oc_q        <= oc_d;
            idle_q      <= idle_d;
            ld_ready_q  <= ld_ready_d;
            err_q       <= err_d;
            mul_valid_q <= mul_valid_d;
            mul_row_q   <= mul_row_d;
            mul_col_q   <= mul_col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            c_q[rc_q[5:0]] <= bus.mul_out;
        end
    end

    always_comb begin
        state_d     = state_q;
        lc_d        = lc_q;
        k_d         = k_q;
        rc_d        = rc_q;
        oc_d        = oc_q;
        idle_d      = idle_q;
        err_d       = 1'b0;
        mul_valid_d = 1'b0;
        mul_row_d   = mul_row_q;
        mul_col_d   = mul_col_q;

        if (capture) begin
            rc_d = rc_q + 7'd1;
        end

        unique case (state_q)
            ST_LOAD: begin
                if (ld_xfer) begin
                    lc_d = lc_q + 4'd1;
                    if (lc_q == 4'd15) begin
                        state_d     = ST_ISSUE;
                        k_d         = '0;
                        rc_d        = '0;
                        mul_valid_d = 1'b1;
                        mul_row_d   = a_rdata;
                        mul_col_d   = b_rdata;
                    end
                end
            end

            ST_ISSUE: begin
                if (k_q == 6'(NPAIR - 1)) begin
                    state_d = ST_DRAIN;
                    idle_d  = '0;
                end else begin
                    k_d         = k_q + 6'd1;
                    mul_valid_d = 1'b1;
                    mul_row_d   = a_rdata;
                    mul_col_d   = b_rdata;
                end
            end

            ST_DRAIN: begin
                if (rc_q == 7'(NPAIR)) begin
                    state_d = ST_OUTPUT;
                    oc_d    = '0;
                end else if (bus.mul_validity) begin
                    idle_d = '0;
                end else if (idle_inc == IDLE_W'(DRAIN_TIMEOUT)) begin
                    // Lost result: abandon the product and accept a fresh load.
                    state_d = ST_LOAD;
                    err_d   = 1'b1;
                    lc_d    = '0;
                    rc_d    = '0;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end

            ST_OUTPUT: begin
                if (res_xfer) begin
                    if (oc_q == 6'(NPAIR - 1)) begin
                        state_d = ST_LOAD;
                        oc_d    = '0;
                        lc_d    = '0;
                        rc_d    = '0;
                    end else begin
                        oc_d = oc_q + 6'd1;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase

        ld_ready_d = (state_d == ST_LOAD);
    end

    assign bus.ld_ready    = ld_ready_q;
    assign bus.mul_row     = mul_row_q;
    assign bus.mul_column  = mul_col_q;
    assign bus.mul_validin = mul_valid_q;
    assign bus.res_valid   = (state_q == ST_OUTPUT);
    assign bus.res_last    = (state_q == ST_OUTPUT) && (oc_q == 6'(NPAIR - 1));
    assign bus.res_data    = (state_q == ST_OUTPUT) ? c_q[oc_q] : FP_ZERO;
    assign busy            = (state_q != ST_LOAD);
    assign err             = err_q;

endmodule
